// File: rtl/handshake_input_fifo.sv
// handshake_input_fifo
//   Receive side of the router RTS/DCTS handshake. Answers an upstream request
//   (DRTS) with a one-cycle CTS pulse, capturing RX on that same edge, and
//   buffers flits for the five local output arbiters to drain.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   DRTS       upstream request-to-send, held with RX stable until CTS is seen
//   RX         incoming flit
//   read_en_*  one-hot pop requests from the N/E/W/S/L output arbiters
//   CTS        clear-to-send pulse back to upstream DCTS
//   Data_out   head flit (combinational), zero when empty
//   empty      no flits stored
//   full       DEPTH flits stored
//   count      current occupancy
module handshake_input_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         DRTS,
  input  logic [DATA_WIDTH-1:0]        RX,
  input  logic                         read_en_N,
  input  logic                         read_en_E,
  input  logic                         read_en_W,
  input  logic                         read_en_S,
  input  logic                         read_en_L,
  output logic                         CTS,
  output logic [DATA_WIDTH-1:0]        Data_out,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  cts_q, cts_d;
  logic                  rd_req, wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign CTS   = cts_q;

  assign rd_req = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;

  // full is the registered view, so a pop on the same edge does not open a slot
  // for the handshake until the following edge.
  assign cts_d = DRTS & ~cts_q & ~full;
  assign wr_en = cts_d;
  assign rd_en = rd_req & ~empty;

  assign Data_out = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so natural pointer overflow wraps mod DEPTH.
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cts_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cts_q    <= cts_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; empty masks stale contents on Data_out.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= RX;
  end

endmodule

// File: tb/tb_handshake_input_fifo.sv
module tb_handshake_input_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          DRTS;
  logic [DW-1:0] RX;
  logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic          CTS;
  logic [DW-1:0] Data_out;
  logic          empty, full;
  logic [CW-1:0] count;

  handshake_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .DRTS      (DRTS),
    .RX        (RX),
    .read_en_N (read_en_N),
    .read_en_E (read_en_E),
    .read_en_W (read_en_W),
    .read_en_S (read_en_S),
    .read_en_L (read_en_L),
    .CTS       (CTS),
    .Data_out  (Data_out),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference model: a flit queue plus the expected CTS level.
  logic [DW-1:0] q[$];
  logic          m_cts;
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] nxt;
  logic          pending;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] exp_head;
    exp_head = (q.size() != 0) ? q[0] : '0;
    check({tag, ".cts"},   DW'(CTS),   DW'(m_cts));
    check({tag, ".count"}, DW'(count), DW'(q.size()));
    check({tag, ".empty"}, DW'(empty), DW'(q.size() == 0));
    check({tag, ".full"},  DW'(full),  DW'(q.size() == DEPTH));
    check({tag, ".data"},  Data_out,   exp_head);
  endtask

  // mask bits: {N,E,W,S,L}
  task automatic step(input string tag, input logic drts, input logic [DW-1:0] rx,
                      input logic [4:0] mask);
    logic acc, pop;
    DRTS = drts; RX = rx;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = mask;
    acc = drts && !m_cts && (q.size() != DEPTH);
    pop = (mask != 5'b0) && (q.size() != 0);
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(rx);
    m_cts = acc;
    check_all(tag);
  endtask

  // Hold DRTS with a stable flit until the model says it was accepted.
  task automatic send_flit(input string tag, input logic [DW-1:0] v);
    bit done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      step(tag, 1'b1, v, 5'b0);
      done = m_cts;
    end
    if (!done) check({tag, ".timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b0; DRTS = 1'b0; RX = '0;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = 5'b0;
    m_cts = 1'b0;
    #2;
    check_all("reset");
    #10 rst = 1'b1;

    // Basic write: CTS one edge after DRTS rises.
    step("basic", 1'b1, 32'hA5A5_0001, 5'b0);
    check("basic.cts_seen", DW'(CTS), 32'd1);
    check("basic.head", Data_out, 32'hA5A5_0001);
    step("basic.drop", 1'b0, 32'h0, 5'b0);
    step("basic.pop", 1'b0, 32'h0, 5'b00001);

    // Fill with DRTS held high, RX advancing after each CTS.
    nxt = 32'h1;
    for (int i = 0; i < 10; i++) begin
      step("fill", 1'b1, nxt, 5'b0);
      if (m_cts) nxt++;
    end
    check("fill.full", DW'(full), 32'd1);
    check("fill.count", DW'(count), 32'd4);

    // Pop at full: no CTS on that edge, CTS on the next.
    step("popfull", 1'b1, nxt, 5'b01000);
    check("popfull.nocts", DW'(CTS), 32'd0);
    step("popfull.next", 1'b1, nxt, 5'b0);
    check("popfull.cts", DW'(CTS), 32'd1);
    check("popfull.count", DW'(count), 32'd4);
    step("popfull.idle", 1'b0, 32'h0, 5'b0);

    // Drain, then interleave six writes and six reads across the wrap.
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 32'h0, 5'b10000);
    nxt = 32'h10;
    for (int i = 0; i < 30 && (nxt != 32'h16 || q.size() != 0); i++) begin
      step("wrap", nxt != 32'h16, nxt, (i % 3 == 2) ? 5'b00100 : 5'b0);
      if (m_cts) nxt++;
    end
    check("wrap.empty", DW'(empty), 32'd1);

    // Simultaneous write and read at count=2.
    send_flit("sim.a", 32'h5);
    step("sim.gap", 1'b0, 32'h0, 5'b0);
    send_flit("sim.b", 32'h6);
    step("sim.gap2", 1'b0, 32'h0, 5'b0);
    step("sim.both", 1'b1, 32'h7, 5'b00001);
    check("sim.count", DW'(count), 32'd2);
    check("sim.head", Data_out, 32'h6);
    step("sim.idle", 1'b0, 32'h0, 5'b0);
    for (int i = 0; i < 3; i++) step("sim.drain", 1'b0, 32'h0, 5'b11111);
    step("rdempty", 1'b0, 32'h0, 5'b11111);

    // Async reset while CTS=1 and count=3.
    send_flit("ar.a", 32'h21);
    step("ar.gap", 1'b0, 32'h0, 5'b0);
    send_flit("ar.b", 32'h22);
    step("ar.gap2", 1'b0, 32'h0, 5'b0);
    send_flit("ar.c", 32'h23);
    check("ar.pre_count", DW'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    q.delete(); m_cts = 1'b0;
    check_all("ar.async");
    #2 rst = 1'b1;
    step("ar.after", 1'b1, 32'h24, 5'b0);
    check("ar.cts", DW'(CTS), 32'd1);
    step("ar.idle", 1'b0, 32'h0, 5'b0);

    // Randomized traffic against the model.
    pending = 1'b0;
    nxt = 32'h0;
    for (int i = 0; i < 400; i++) begin
      logic [4:0] mask;
      if (!pending && $urandom_range(0, 2) != 0) begin
        pending = 1'b1;
        nxt = $urandom;
      end
      mask = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
      step("rand", pending, nxt, mask);
      if (m_cts) pending = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/handshake_input_fifo.md
Name: handshake_input_fifo

Overview:
- Receive-side partner of the router output arbiter's RTS/DCTS handshake.
- Sits at each router input port. It answers the upstream arbiter's RTS (seen here as DRTS) with a one-cycle CTS pulse, which the sender sees as DCTS, and captures the flit on that handshake.
- Buffered flits are drained by the five local output arbiters through one-hot read enables.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, number of flit slots. Must be a power of two, ≥2.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset. Asynchronous, active-low: asserted when 0.
- DRTS  input  1  request-to-send from upstream arbiter's RTS; held high with RX stable until CTS is seen.
- RX  input  DATA_WIDTH  incoming flit, valid while DRTS=1.
- read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  input  1 each  pop requests from the five output arbiters.
- CTS  output  1  clear-to-send pulse to upstream DCTS.
- Data_out  output  DATA_WIDTH  head flit, combinational.
- empty  output  1  no flits stored.
- full  output  1  DEPTH flits stored.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - CTS=0, count=0, wr_ptr=rd_ptr=0, so empty=1 and full=0.
  - Data_out=0.
  - Memory contents are not cleared.
- State: registered CTS, wr_ptr, rd_ptr, count, memory[DEPTH].
- empty = (count==0), full = (count==DEPTH); both combinational from count.
- Handshake / write:
  - CTS_next = DRTS & ~CTS & ~full.
  - On the edge where CTS_next=1: RX is written to mem[wr_ptr], wr_ptr increments mod DEPTH, and CTS becomes 1 for exactly one cycle.
  - A flit is therefore accepted one edge after DRTS rises, provided there is space.
  - The sender drops RTS after seeing DCTS. If DRTS stays high (back-to-back flits), CTS alternates 0/1, giving at most one flit per 2 cycles.
  - While CTS=1, no new write occurs even if DRTS=1.
- Read:
  - rd_req = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L.
  - Effective read = rd_req & ~empty. On that edge rd_ptr increments mod DEPTH.
  - More than one enable set counts as a single pop.
  - Read while empty is ignored: no pointer or count change.
- Data_out = mem[rd_ptr] when ~empty, else 0. Zero latency: the head is visible in the same cycle the count becomes nonzero.
- Count update:
  - write only: +1.
  - read only: −1.
  - both on the same edge: unchanged, and both pointers advance.
  - count never exceeds DEPTH or drops below 0.
- Full boundary:
  - While full, CTS is not issued, even if a read happens on the same edge (conservative, registered full).
  - CTS is issued on the edge after count drops below DEPTH, if DRTS is still high.
- Wrap-around: pointers wrap from DEPTH−1 to 0. Data order is strictly FIFO across the wrap.
- Reset mid-transfer:
  - If rst asserts while CTS=1 or DRTS=1, all state clears immediately and any partially handshaken flit is dropped.
  - After release, a held DRTS produces a fresh CTS on the next edge.
- Reads and writes are independent of the flit content.

Test Plan:
- Basic write: after reset, DRTS=1 with RX=0xA5A5_0001 → CTS=1 exactly one cycle after DRTS rises; count=1, empty=0, Data_out=0xA5A5_0001.
- Fill and full: four flits 0x1..0x4 with DRTS kept high and no reads → CTS pulses every 2nd cycle, full=1 at count=4. A fifth DRTS gets no CTS while full.
- Pop at full: at full, read_en_E=1 for one cycle while DRTS=1 → no CTS on that edge; CTS on the next edge; Data_out sequence 0x1, 0x2, ...; count returns to 4.
- Wrap-around order: write 6 flits and read 6 in interleaved order → outputs match the input order 0x10..0x15; count and pointers wrap correctly.
- Simultaneous: count=2, write 0x7 and read_en_L on the same edge → count stays 2 and Data_out advances to the next flit. Read while empty → count stays 0, Data_out=0.
- Async reset mid-handshake: drop rst to 0 between clock edges while CTS=1 and count=3 → CTS=0, count=0, empty=1 immediately without waiting for a clock edge; after release, a held DRTS gets CTS on the next edge.
